// File: rtl/fetch_sequencer_if.sv
// Fetch-control bundle between the pipeline (master) and fetch_sequencer (slave).
// Optional macro FETCH_PERF_EN adds the performance-counter outputs.
interface fetch_sequencer_if;
  // D/M-stage inputs to the sequencer
  logic [31:0] pc_f;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] target_b;
  logic [31:0] target_j;
  logic [31:0] target_jr;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  // Outputs toward the IFU and debug
  logic [31:0] pc_next;
  logic        pc_en;
  logic        flush_fd;
  logic        target_misaligned;
  logic        stall_timeout;
  logic [1:0]  state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_redirects;
`endif

  modport master (
    output pc_f, stall, npc_sel, br_taken, target_b, target_j, target_jr,
    output exc_req, eret_req, epc,
`ifdef FETCH_PERF_EN
    input  perf_stall_cycles, perf_redirects,
`endif
    input  pc_next, pc_en, flush_fd, target_misaligned, stall_timeout, state
  );

  modport slave (
    input  pc_f, stall, npc_sel, br_taken, target_b, target_j, target_jr,
    input  exc_req, eret_req, epc,
`ifdef FETCH_PERF_EN
    output perf_stall_cycles, perf_redirects,
`endif
    output pc_next, pc_en, flush_fd, target_misaligned, stall_timeout, state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Next-PC selection for the instruction-fetch unit: exception vector, eret,
// stall hold, D-stage redirect, or sequential PC+4, with a one-cycle redirect
// blackout after exception/eret and a sticky stall watchdog.
// Optional macro FETCH_PERF_EN adds stall-cycle and redirect counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
  parameter int unsigned STALL_LIMIT = 64
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StExcBlk  = 2'd1,
    StEretBlk = 2'd2
  } state_e;

  localparam logic [7:0] StallLimit = 8'(STALL_LIMIT);

  state_e      state_q, state_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  logic        d_hit;
  logic [31:0] d_target;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        flush_fd;

  // Decode the D-stage redirect request; untaken branch counts as sequential.
  always_comb begin
    d_hit    = 1'b0;
    d_target = bus.target_b;
    case (bus.npc_sel)
      2'b01: begin
        d_hit    = bus.br_taken;
        d_target = bus.target_b;
      end
      2'b10: begin
        d_hit    = 1'b1;
        d_target = bus.target_j;
      end
      2'b11: begin
        d_hit    = 1'b1;
        d_target = bus.target_jr;
      end
      default: ;
    endcase
  end

  // Prioritised next-PC selection and FSM next state.
  always_comb begin
    pc_next  = bus.pc_f + 32'd4;
    pc_en    = 1'b1;
    flush_fd = 1'b0;
    state_d  = StRun;
    if (reset) begin
      pc_next  = RESET_PC;
      pc_en    = 1'b0;
      flush_fd = 1'b1;
      state_d  = StRun;
    end else if (bus.exc_req) begin
      pc_next  = EXC_VECTOR;
      flush_fd = 1'b1;
      state_d  = StExcBlk;
    end else if (bus.eret_req) begin
      pc_next  = bus.epc;
      flush_fd = 1'b1;
      state_d  = StEretBlk;
    end else if (bus.stall) begin
      // D operands may be stale; blackout states hold until a free cycle.
      pc_next = bus.pc_f;
      pc_en   = 1'b0;
      if (state_q == StExcBlk || state_q == StEretBlk) begin
        state_d = state_q;
      end
    end else if (state_q == StRun && d_hit) begin
      pc_next = d_target;
    end
  end

  // Watchdog next state: saturating run length of consecutive stalls.
  always_comb begin
    wd_cnt_d = 8'd0;
    if (bus.stall) begin
      wd_cnt_d = (wd_cnt_q == 8'hff) ? 8'hff : wd_cnt_q + 8'd1;
    end
    timeout_d = timeout_q | (wd_cnt_d >= StallLimit);
  end

  // FSM and watchdog registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      wd_cnt_q  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_red_q;
  logic        redir_evt;

  assign redir_evt = bus.exc_req | bus.eret_req |
                     (~bus.stall & (state_q == StRun) & d_hit);

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= 32'd0;
      perf_red_q   <= 32'd0;
    end else begin
      if (!pc_en) perf_stall_q <= perf_stall_q + 32'd1;
      if (redir_evt) perf_red_q <= perf_red_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_redirects    = perf_red_q;
`endif

  assign bus.pc_next           = pc_next;
  assign bus.pc_en             = pc_en;
  assign bus.flush_fd          = flush_fd;
  assign bus.target_misaligned = |pc_next[1:0];
  assign bus.stall_timeout     = timeout_q;
  assign bus.state             = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed steps then random traffic,
// all compared against a rule-level reference model.
module tb_fetch_sequencer;

  localparam logic [31:0] ResetPc   = 32'h0000_3000;
  localparam logic [31:0] ExcVector = 32'h0000_4180;
  localparam int          Limit     = 64;

  logic clk;
  logic reset;
  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_state = 0;    // 0 run, 1 after exception, 2 after eret
  int          m_run   = 0;    // consecutive stall cycles, capped at 255
  bit          m_to    = 1'b0;
  logic [31:0] m_ps    = '0;
  logic [31:0] m_red   = '0;
  logic [31:0] last_pc;
  logic        last_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model for the current inputs, then clock once.
  task automatic step(input string tag);
    logic [31:0] e_pc;
    logic        e_en, e_fl, hit, evt;
    logic [31:0] tgt;
    #1;
    hit = 1'b0;
    tgt = '0;
    if (bus.npc_sel == 2'b01 && bus.br_taken) begin hit = 1'b1; tgt = bus.target_b; end
    if (bus.npc_sel == 2'b10) begin hit = 1'b1; tgt = bus.target_j; end
    if (bus.npc_sel == 2'b11) begin hit = 1'b1; tgt = bus.target_jr; end
    evt = 1'b0;
    if (reset) begin
      e_pc = ResetPc; e_en = 1'b0; e_fl = 1'b1;
    end else if (bus.exc_req) begin
      e_pc = ExcVector; e_en = 1'b1; e_fl = 1'b1; evt = 1'b1;
    end else if (bus.eret_req) begin
      e_pc = bus.epc; e_en = 1'b1; e_fl = 1'b1; evt = 1'b1;
    end else if (bus.stall) begin
      e_pc = bus.pc_f; e_en = 1'b0; e_fl = 1'b0;
    end else if (m_state == 0 && hit) begin
      e_pc = tgt; e_en = 1'b1; e_fl = 1'b0; evt = 1'b1;
    end else begin
      e_pc = bus.pc_f + 32'd4; e_en = 1'b1; e_fl = 1'b0;
    end
    chk({tag, ".pc_next"}, bus.pc_next, e_pc);
    chk({tag, ".pc_en"}, 32'(bus.pc_en), 32'(e_en));
    chk({tag, ".flush_fd"}, 32'(bus.flush_fd), 32'(e_fl));
    chk({tag, ".misaligned"}, 32'(bus.target_misaligned), 32'(e_pc[1:0] != 2'b00));
    chk({tag, ".state"}, 32'(bus.state), 32'(m_state));
    chk({tag, ".timeout"}, 32'(bus.stall_timeout), 32'(m_to));
`ifdef FETCH_PERF_EN
    chk({tag, ".perf_stall"}, bus.perf_stall_cycles, m_ps);
    chk({tag, ".perf_redir"}, bus.perf_redirects, m_red);
`endif
    last_pc = e_pc;
    last_en = e_en;
    @(posedge clk);
    #1;
    if (reset) begin
      m_state = 0; m_run = 0; m_to = 1'b0; m_ps = '0; m_red = '0;
    end else begin
      if (!e_en) m_ps = m_ps + 32'd1;
      if (evt) m_red = m_red + 32'd1;
      if (bus.exc_req) m_state = 1;
      else if (bus.eret_req) m_state = 2;
      else if (!bus.stall) m_state = 0;
      m_run = bus.stall ? ((m_run < 255) ? m_run + 1 : 255) : 0;
      if (m_run >= Limit) m_to = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.npc_sel = 2'b00; bus.br_taken = 1'b0;
    bus.exc_req = 1'b0; bus.eret_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.pc_f = '0; bus.target_b = '0; bus.target_j = '0; bus.target_jr = '0; bus.epc = '0;
    idle_inputs();
    step("reset0");
    step("reset1");

    // Free-running sequential fetch with pc_f following pc_next
    reset = 1'b0;
    bus.pc_f = ResetPc;
    for (int i = 0; i < 3; i++) begin
      step("seq");
      if (last_en) bus.pc_f = last_pc;
    end
    chk("seq_end_pc", bus.pc_f, 32'h0000_300c);

    // Branch taken / not taken
    bus.pc_f = 32'h3010; bus.npc_sel = 2'b01; bus.br_taken = 1'b1; bus.target_b = 32'h3100;
    step("br_taken");
    bus.br_taken = 1'b0;
    step("br_not_taken");

    // Stall masks jr, then jr goes through
    bus.npc_sel = 2'b11; bus.target_jr = 32'h3200; bus.stall = 1'b1;
    step("stall_jr");
    bus.stall = 1'b0;
    step("jr");

    // Exception overrides stall; blackout masks j
    bus.stall = 1'b1; bus.exc_req = 1'b1; bus.npc_sel = 2'b00;
    step("exc");
    idle_inputs();
    bus.pc_f = 32'h4180; bus.npc_sel = 2'b10; bus.target_j = 32'h3300;
    step("exc_blk");
    bus.pc_f = 32'h4184; bus.npc_sel = 2'b00;
    step("exc_back");

    // eret to misaligned epc, then exception beats eret
    bus.eret_req = 1'b1; bus.epc = 32'h3022;
    step("eret");
    bus.exc_req = 1'b1;
    step("exc_and_eret");
    idle_inputs();
    step("after_both");

    // Watchdog from a clean reset
    reset = 1'b1;
    step("wd_reset");
    reset = 1'b0;
    bus.stall = 1'b1;
    for (int i = 0; i < Limit; i++) step("wd_stall");
    chk("wd_set", 32'(bus.stall_timeout), 32'd1);
`ifdef FETCH_PERF_EN
    chk("wd_perf_stall", bus.perf_stall_cycles, 32'd64);
`endif
    bus.stall = 1'b0;
    step("wd_sticky0");
    step("wd_sticky1");

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 63) == 0);
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.exc_req  = ($urandom_range(0, 15) == 0);
      bus.eret_req = ($urandom_range(0, 15) == 0);
      bus.npc_sel  = 2'($urandom_range(0, 3));
      bus.br_taken = 1'($urandom_range(0, 1));
      bus.pc_f     = $urandom;
      bus.target_b = $urandom;
      bus.target_j = $urandom;
      bus.target_jr = $urandom;
      bus.epc      = $urandom;
      if ($urandom_range(0, 1) == 1) bus.pc_f[1:0] = 2'b00;
      step("rand");
    end

    // Long stall within random phase can also trip; finish with reset clearing it
    reset = 1'b1;
    idle_inputs();
    step("final_reset");
    reset = 1'b0;
    step("final_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
